// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: psum word width and the row-beat layout.
// The row beat at the default row length travels between the PU rows and the arbiter.
package cnn_pkg;

  localparam int PSUM_W       = 40;
  localparam int ROW_LEN_DFLT = 16;

  typedef logic [PSUM_W-1:0] psum_word_t;

  typedef struct packed {
    psum_word_t [ROW_LEN_DFLT-1:0] data;
    logic       [ROW_LEN_DFLT-1:0] mask;
  } row_beat_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last grant, and the pointer moves only when adv_i is high.
// The grant is combinational from req_i and the pointer, so it adds no latency; adv_i is the caller's accept.
module rr_arbiter #(
  parameter  int N     = 16,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req_i,
  input  logic             adv_i,
  output logic [N-1:0]     gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = IDX_W'(idx);
      end
    end
    gnt_vld_o = found;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && gnt_vld_o) ptr_d = gnt_idx_o;
  end

  // The pointer starts at the last row, so row 0 wins the first search.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= IDX_W'(N - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/psum_row_arbiter.sv
// Shares one write master among NUM_ROWS psum rows. A beat accepted at one edge is on icm_* in the next cycle.
// A downstream stall freezes the output register and holds every row waitreq high.
module psum_row_arbiter
  import cnn_pkg::*;
#(
  parameter  int NUM_ROWS   = 16,
  parameter  int PU_ROW_LEN = 16,
  parameter  int ADDR_W     = 32,
  parameter  int CNT_W      = 16,
  localparam int IDX_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_ROWS-1:0][PU_ROW_LEN-1:0][PSUM_W-1:0] row_psum_writedata_i,
  input  logic [NUM_ROWS-1:0]                    row_psum_cs_i,
  input  logic [NUM_ROWS-1:0][PU_ROW_LEN-1:0]    row_psum_wordenable_i,
  output logic [NUM_ROWS-1:0]                    row_psum_waitreq_o,
  output logic [PU_ROW_LEN-1:0][PSUM_W-1:0]      icm_writedata_o,
  output logic [PU_ROW_LEN-1:0]                  icm_wordenable_o,
  output logic [ADDR_W-1:0]                      icm_address_o,
  output logic [IDX_W-1:0]                       icm_rowid_o,
  output logic                                   icm_cs_o,
  input  logic                                   icm_waitreq_i,
  input  logic [ADDR_W-1:0]                      cfg_base_addr_i,
  input  logic [ADDR_W-1:0]                      cfg_row_stride_i,
  input  logic                                   cfg_clear_i,
  output logic                                   busy_o
);

  typedef struct packed {
    psum_word_t [PU_ROW_LEN-1:0] data;
    logic       [PU_ROW_LEN-1:0] mask;
  } beat_t;

  logic                               out_valid_q, out_valid_d;
  beat_t                              beat_q, beat_d;
  logic [ADDR_W-1:0]                  addr_q, addr_d;
  logic [IDX_W-1:0]                   rowid_q, rowid_d;
  logic [NUM_ROWS-1:0][CNT_W-1:0]     cnt_q, cnt_d;

  logic                load;
  logic                adv;
  logic [NUM_ROWS-1:0] gnt_oh;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_vld;

  rr_arbiter #(.N(NUM_ROWS)) u_rr (
    .clock     (clock),
    .reset     (reset),
    .req_i     (row_psum_cs_i),
    .adv_i     (adv),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    load = !out_valid_q || !icm_waitreq_i;
    // Gated by reset so that no row sees an accept while the register is held in reset.
    adv  = load && gnt_vld && !reset;
    row_psum_waitreq_o = ~({NUM_ROWS{adv}} & gnt_oh);

    out_valid_d = out_valid_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    rowid_d     = rowid_q;
    cnt_d       = cnt_q;

    if (load) out_valid_d = gnt_vld;
    if (adv) begin
      beat_d.data    = row_psum_writedata_i[gnt_idx];
      beat_d.mask    = row_psum_wordenable_i[gnt_idx];
      addr_d         = cfg_base_addr_i + ADDR_W'(gnt_idx) * cfg_row_stride_i
                       + ADDR_W'(cnt_q[gnt_idx]);
      rowid_d        = gnt_idx;
      cnt_d[gnt_idx] = cnt_q[gnt_idx] + CNT_W'(1);
    end
    // The captured beat above already used the old count; the clear still wins.
    if (cfg_clear_i) cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      beat_q      <= '0;
      addr_q      <= '0;
      rowid_q     <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      rowid_q     <= rowid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign icm_cs_o         = out_valid_q;
  assign icm_writedata_o  = beat_q.data;
  assign icm_wordenable_o = beat_q.mask;
  assign icm_address_o    = addr_q;
  assign icm_rowid_o      = rowid_q;
  assign busy_o           = out_valid_q || (|row_psum_cs_i);

endmodule
